// File: rtl/mem_stage_if.sv
`timescale 1ns/1ps
// Data-memory request/acknowledge port between the MEM stage (master) and memory (slave).
// Valid/ready rule: mem_req stays high with mem_we/mem_addr/mem_wdata stable until the single-cycle mem_ack strobe; mem_rdata is valid only while mem_ack is high.
interface mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// Memory-access stage: issues one req/ack access per load/store, stalls upstream while it is
// outstanding, aborts hung accesses with a watchdog, and loads the MEM/WB pipeline register.
module mem_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        address,
  input  logic [15:0]        r0data,
  input  logic [15:0]        Din,
  input  logic [15:0]        instructions4,
  input  logic               wEnable,
  input  logic               mux3sels4,
  input  logic               regWrites4,
  input  logic               r0writes4,
  mem_stage_if.master        mem,
  output logic               stall,
  output logic [15:0]        wbData,
  output logic [15:0]        r0dataWB,
  output logic [15:0]        instructionsWB,
  output logic               regWritesWB,
  output logic               r0writesWB,
  output logic               err,
  output logic               dbg_state
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          access;
  logic          ack_hit;
  logic          expire;

  assign access    = wEnable | mux3sels4;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // mem_ack takes priority over the watchdog when both land in the same cycle.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    ack_hit   = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stall     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (mem.mem_ack) begin
          ack_hit   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt            <= '0;
      mem.mem_req    <= 1'b0;
      mem.mem_we     <= 1'b0;
      mem.mem_addr   <= '0;
      mem.mem_wdata  <= '0;
      wbData         <= '0;
      r0dataWB       <= '0;
      instructionsWB <= '0;
      regWritesWB    <= 1'b0;
      r0writesWB     <= 1'b0;
      err            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!access) begin
            wbData         <= address;
            r0dataWB       <= r0data;
            instructionsWB <= instructions4;
            regWritesWB    <= regWrites4;
            r0writesWB     <= r0writes4;
          end else begin
            cnt            <= '0;
            mem.mem_req    <= 1'b1;
            mem.mem_we     <= wEnable;
            mem.mem_addr   <= address;
            mem.mem_wdata  <= Din;
            instructionsWB <= '0;
            regWritesWB    <= 1'b0;
            r0writesWB     <= 1'b0;
          end
        end
        BUSY: begin
          // Upstream is stalled, so the EX/MEM inputs still hold the access's instruction.
          if (ack_hit) begin
            mem.mem_req    <= 1'b0;
            wbData         <= mem.mem_we ? Din : mem.mem_rdata;
            r0dataWB       <= r0data;
            instructionsWB <= instructions4;
            regWritesWB    <= regWrites4;
            r0writesWB     <= r0writes4;
          end else if (expire) begin
            mem.mem_req    <= 1'b0;
            err            <= 1'b1;
            instructionsWB <= instructions4;
            regWritesWB    <= 1'b0;
            r0writesWB     <= 1'b0;
          end else begin
            cnt            <= cnt + 1'b1;
            instructionsWB <= '0;
            regWritesWB    <= 1'b0;
            r0writesWB     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
// Randomized self-checking bench for mem_stage: a transaction-level model predicts stall,
// request fields and MEM/WB contents from each instruction and the chosen memory latency.
module tb_mem_stage;
  localparam int TIMEOUT = 4;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] r0d;
    logic [15:0] din;
    logic [15:0] instr;
    logic        we;
    logic        msel;
    logic        rw;
    logic        r0w;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] address, r0data, Din, instructions4;
  logic        wEnable, mux3sels4, regWrites4, r0writes4;
  logic        stall;
  logic [15:0] wbData, r0dataWB, instructionsWB;
  logic        regWritesWB, r0writesWB, err, dbg_state;

  mem_stage_if mif ();

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .address        (address),
    .r0data         (r0data),
    .Din            (Din),
    .instructions4  (instructions4),
    .wEnable        (wEnable),
    .mux3sels4      (mux3sels4),
    .regWrites4     (regWrites4),
    .r0writes4      (r0writes4),
    .mem            (mif),
    .stall          (stall),
    .wbData         (wbData),
    .r0dataWB       (r0dataWB),
    .instructionsWB (instructionsWB),
    .regWritesWB    (regWritesWB),
    .r0writesWB     (r0writesWB),
    .err            (err),
    .dbg_state      (dbg_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  // Scoreboard state
  logic [49:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        exp_err  = 1'b0;
  logic [15:0] last_wb  = 16'h0;
  logic        wb_known = 1'b1;

  task automatic check(input string tag, input logic [49:0] obs, input logic [49:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [49:0] pack(input logic [15:0] i, input logic [15:0] w,
                                       input logic [15:0] r, input logic a, input logic b);
    return {i, w, r, a, b};
  endfunction

  function automatic logic [49:0] wb_now();
    return {instructionsWB, wbData, r0dataWB, regWritesWB, r0writesWB};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input ins_t t);
    address       = t.addr;
    r0data        = t.r0d;
    Din           = t.din;
    instructions4 = t.instr;
    wEnable       = t.we;
    mux3sels4     = t.msel;
    regWrites4    = t.rw;
    r0writes4     = t.r0w;
  endtask

  function automatic ins_t mk(input logic [15:0] a, input logic [15:0] r, input logic [15:0] d,
                              input logic [15:0] i, input logic we, input logic ms,
                              input logic rw, input logic r0w);
    ins_t t;
    t.addr = a; t.r0d = r; t.din = d; t.instr = i;
    t.we = we; t.msel = ms; t.rw = rw; t.r0w = r0w;
    return t;
  endfunction

  // Present one instruction; delay = BUSY cycles before mem_ack (>= TIMEOUT means never).
  // fixed_rd[16] selects fixed_rd[15:0] as the read data returned with the ack.
  task automatic run(input ins_t t, input int delay, input logic [16:0] fixed_rd);
    logic        acc;
    logic        done;
    logic [15:0] rd;
    logic [49:0] e;
    acc = t.we | t.msel;
    drive(t);
    mif.mem_ack = 1'b0;
    @(negedge clk);
    check("stall_first", 50'(stall), 50'(acc));
    check("req_first", 50'(mif.mem_req), 50'(0));
    tick();
    if (!acc) begin
      last_wb  = t.addr;
      wb_known = 1'b1;
      check("wb_alu", wb_now(), pack(t.instr, t.addr, t.r0d, t.rw, t.r0w));
    end else begin
      done = 1'b0;
      for (int k = 0; k < TIMEOUT && !done; k++) begin
        rd = fixed_rd[16] ? fixed_rd[15:0] : 16'($urandom);
        mif.mem_rdata = rd;
        mif.mem_ack   = (k == delay);
        @(negedge clk);
        check("req_busy", 50'(mif.mem_req), 50'(1));
        check("req_fields", 50'({mif.mem_we, mif.mem_addr, mif.mem_wdata}),
              50'({t.we, t.addr, t.din}));
        check("bubble_ctl", 50'({instructionsWB, regWritesWB, r0writesWB}), 50'(0));
        if (wb_known) check("bubble_hold", 50'(wbData), 50'(last_wb));
        if (k == delay) begin
          done = 1'b1;
          check("stall_ack", 50'(stall), 50'(0));
          exp_q.push_back(pack(t.instr, t.we ? t.din : rd, t.r0d, t.rw, t.r0w));
        end else if (k == TIMEOUT - 1) begin
          done = 1'b1;
          check("stall_timeout", 50'(stall), 50'(0));
          exp_err = 1'b1;
        end else begin
          check("stall_wait", 50'(stall), 50'(1));
        end
        tick();
      end
      mif.mem_ack = 1'b0;
      check("req_drop", 50'(mif.mem_req), 50'(0));
      check("err", 50'(err), 50'(exp_err));
      if (exp_q.size() > 0) begin
        e        = exp_q.pop_front();
        last_wb  = e[33:18];
        wb_known = 1'b1;
        check("wb_commit", wb_now(), e);
      end else begin
        wb_known = 1'b0;
        check("wb_abort", 50'({instructionsWB, regWritesWB, r0writesWB}), 50'({t.instr, 2'b00}));
      end
    end
  endtask

  initial begin
    ins_t t;
    rst_n = 1'b0;
    drive(mk(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 16'hFFFF;

    // Reset with mem_ack toggling
    repeat (2) begin
      mif.mem_ack = ~mif.mem_ack;
      tick();
    end
    check("rst_outs", {wb_now()}, 50'(0));
    check("rst_mem", 50'({mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata}), 50'(0));
    check("rst_misc", 50'({err, dbg_state, stall}), 50'(0));
    mif.mem_ack = 1'b0;
    rst_n = 1'b1;

    // Directed cases
    run(mk(16'h1234, 16'h0042, 16'h9999, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0), 0, 17'h0);
    run(mk(16'h00A0, 16'h0077, 16'h0000, 16'h2222, 1'b0, 1'b1, 1'b1, 1'b0), 3, 17'h1BEEF);
    run(mk(16'h0010, 16'h0033, 16'h5A5A, 16'h3333, 1'b1, 1'b0, 1'b0, 1'b0), 0, 17'h0);
    run(mk(16'h0020, 16'h0044, 16'h0000, 16'h4444, 1'b0, 1'b1, 1'b1, 1'b1), 1, 17'h0);
    run(mk(16'h0030, 16'h0055, 16'hC0DE, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b1), 2, 17'h0);
    run(mk(16'h0040, 16'h0066, 16'h0000, 16'h6666, 1'b0, 1'b1, 1'b1, 1'b1), 99, 17'h0);
    run(mk(16'h0050, 16'h0088, 16'h0000, 16'h7777, 1'b0, 1'b0, 1'b1, 1'b1), 0, 17'h0);

    // Randomized stream
    for (int n = 0; n < 300; n++) begin
      t = mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
             1'($urandom), 1'($urandom));
      run(t, $urandom_range(0, TIMEOUT + 1), 17'h0);
    end

    // Reset during BUSY, then a late ack must be ignored
    drive(mk(16'h0BAD, 16'h0001, 16'h0000, 16'h8888, 1'b0, 1'b1, 1'b1, 1'b1));
    tick();
    tick();
    @(negedge clk);
    check("busy_before_rst", 50'({dbg_state, mif.mem_req}), 50'(2'b11));
    rst_n = 1'b0;
    tick();
    exp_err = 1'b0;
    check("rst_busy_req", 50'({mif.mem_req, dbg_state, err}), 50'(0));
    check("rst_busy_wb", wb_now(), 50'(0));
    rst_n = 1'b1;
    drive(mk(16'h7777, 16'h0002, 16'h0000, 16'h9999, 1'b0, 1'b0, 1'b1, 1'b0));
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 16'hDEAD;
    @(negedge clk);
    check("late_ack_stall", 50'(stall), 50'(0));
    tick();
    mif.mem_ack = 1'b0;
    check("late_ack_req", 50'({mif.mem_req, err}), 50'(0));
    check("late_ack_wb", wb_now(), pack(16'h9999, 16'h7777, 16'h0002, 1'b1, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 16-bit pipelined CPU. Consumes the EX/MEM pipeline register outputs (address, r0data, Din, instructions4, wEnable, mux3sels4, regWrites4, r0writes4) and drives a req/ack data-memory port. Stalls the upstream pipeline while an access is outstanding, then loads the MEM/WB pipeline register. Handles loads, stores and pass-through ALU results, and aborts hung accesses with a watchdog.

## Interface
- TIMEOUT, 64: maximum BUSY cycles to wait for mem_ack before aborting (≥2).
- clk  in  1  pipeline clock; all state changes on posedge.
- rst_n  in  1  synchronous, active-low reset.
- address  in  16  memory word address / ALU result 1.
- r0data  in  16  ALU result 2, destined for r0.
- Din  in  16  store data.
- instructions4  in  16  instruction word in MEM.
- wEnable  in  1  store request.
- mux3sels4  in  1  writeback source: 1 = memory read data, 0 = address (ALU result).
- regWrites4, r0writes4  in  1 each  writeback enables.
- mem_req  out  1  registered access request.
- mem_we  out  1  registered; 1 = write.
- mem_addr, mem_wdata  out  16 each  registered access address / write data.
- mem_rdata  in  16  read data, valid when mem_ack = 1.
- mem_ack  in  1  one-cycle completion strobe.
- stall  out  1  combinational; upstream stages and the EX/MEM register hold while 1.
- wbData, r0dataWB, instructionsWB  out  16 each  MEM/WB register.
- regWritesWB, r0writesWB  out  1 each  MEM/WB writeback enables.
- err  out  1  sticky timeout flag.

## Operation
- access = wEnable | mux3sels4. With wEnable = mux3sels4 = 1, the stage performs a write; wbData = Din.
- States: IDLE, BUSY.
- IDLE, access = 0: stall = 0; at the edge MEM/WB loads wbData = address, r0dataWB = r0data, instructionsWB = instructions4, regWritesWB = regWrites4, r0writesWB = r0writes4.
- IDLE, access = 1: stall = 1; at the edge go BUSY. mem_req ← 1, mem_we ← wEnable, mem_addr ← address, mem_wdata ← Din. Clear the watchdog counter. MEM/WB loads a bubble: regWritesWB = r0writesWB = 0, instructionsWB = 0; the data fields hold their values.
- BUSY, mem_ack = 0: stall = 1. Increment the counter. MEM/WB loads a bubble.
- BUSY, mem_ack = 1: stall = 0. At the edge:
  - mem_req ← 0; go IDLE.
  - MEM/WB loads the held instruction. wbData = mem_rdata for a read, Din for a write. The other fields come from the held inputs.
- BUSY, counter = TIMEOUT−1 and mem_ack = 0: stall = 0. At the edge:
  - mem_req ← 0; err ← 1; go IDLE.
  - MEM/WB loads instructionsWB = instructions4 with both write enables forced to 0.
- If mem_ack and timeout coincide, mem_ack wins: normal commit, err unchanged.
- mem_ack in IDLE is ignored.
- mem_we/mem_addr/mem_wdata are stable for the whole BUSY period.
- err clears only on reset.

## Timing
- Reset (rst_n = 0 at posedge): state IDLE, counter 0, and every registered output = 0 (mem_req, mem_we, mem_addr, mem_wdata, all MEM/WB fields, err). stall evaluates from the current inputs after reset.
- Reset during BUSY: mem_req is low the following cycle. Any late mem_ack is ignored.
- Non-memory instruction: 1 cycle, with MEM/WB valid the cycle after presentation.
- Memory instruction with ack in the first BUSY cycle: 2 cycles of occupancy, 1 stall cycle.
- Memory instruction with N wait cycles: N+2 cycles of occupancy.
- Back-to-back accesses: mem_req drops for at least one cycle (the IDLE cycle) between requests.
- Throughput: 1 instruction/cycle without memory ops; at most 1 access per 2 cycles.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with mem_ack toggling -> all outputs 0, state IDLE, no mem_req.
- ALU pass-through: address = 0x1234, r0data = 0x0042, regWrites4 = 1, access = 0 -> stall never high; next cycle wbData = 0x1234, r0dataWB = 0x0042, regWritesWB = 1.
- Load, 3 wait states: address = 0x00A0, mux3sels4 = 1.
  - mem_req high 4 cycles with mem_addr = 0x00A0, mem_we = 0.
  - mem_ack arrives with mem_rdata = 0xBEEF -> wbData = 0xBEEF, regWritesWB = 1.
  - stall high for exactly 4 cycles; regWritesWB = 0 on the bubble cycles.
- Store, zero-wait: wEnable = 1, Din = 0x5A5A, address = 0x0010.
  - One-cycle mem_req, mem_we = 1, mem_wdata = 0x5A5A.
  - Ack in the same cycle -> commit next edge; store followed by a load gives an IDLE gap in mem_req.
- Timeout with TIMEOUT = 4, no ack -> after 4 BUSY cycles mem_req drops, err = 1, regWritesWB = r0writesWB = 0, pipeline resumes.
- Ack on the final timeout cycle -> normal commit, err stays 0.
- Reset asserted during BUSY, then ack arrives after reset -> no commit, err 0, mem_req 0.
